// File: rtl/sdr_pkg.sv
// Shared definitions for the SDRAM command-bus arbiter: command encodings,
// FSM state enum, bus owner codes and the engine command bundle layout.
package sdr_pkg;

  // Engine command bundle: {BA[1:0], A[12:0], nRAS, nCAS, nWE}
  localparam int CMD_W    = 18;
  localparam int BA_LSB   = 16;
  localparam int BA_W     = 2;
  localparam int A_LSB    = 3;
  localparam int A_W      = 13;
  localparam int NRAS_BIT = 2;
  localparam int NCAS_BIT = 1;
  localparam int NWE_BIT  = 0;

  // {nRAS, nCAS, nWE} encodings
  localparam logic [2:0] CMD_NOP          = 3'b111;
  localparam logic [2:0] CMD_ACTIVE       = 3'b011;
  localparam logic [2:0] CMD_READ         = 3'b101;
  localparam logic [2:0] CMD_WRITE        = 3'b100;
  localparam logic [2:0] CMD_PRECHARGE    = 3'b010;
  localparam logic [2:0] CMD_AUTO_REFRESH = 3'b001;

  // Bus owner codes
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_WR   = 2'd1;
  localparam logic [1:0] OWN_RD   = 2'd2;
  localparam logic [1:0] OWN_REF  = 2'd3;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR,
    S_RD,
    S_REF_PRE,
    S_REF_AR
  } state_t;

  // Build a full command bundle from its fields
  function automatic logic [CMD_W-1:0] pack_cmd(input logic [BA_W-1:0] ba,
                                                input logic [A_W-1:0]  a,
                                                input logic [2:0]      cmd);
    return {ba, a, cmd};
  endfunction

  // Bundles the arbiter drives itself; PRECHARGE-ALL needs A[10]=1
  localparam logic [CMD_W-1:0] BUNDLE_NOP = {2'b00, 13'h0000, CMD_NOP};
  localparam logic [CMD_W-1:0] BUNDLE_PRE = {2'b00, 13'h0400, CMD_PRECHARGE};
  localparam logic [CMD_W-1:0] BUNDLE_AR  = {2'b00, 13'h0000, CMD_AUTO_REFRESH};

endpackage

// File: rtl/sdr_ref_timer.sv
// Auto-refresh interval timer. Counts 0..REF_INTERVAL-1 while enabled and
// raises a pending flag on every wrap; a wrap that finds the flag already
// set marks a sticky overrun. REF_INTERVAL must not exceed 2047.
module sdr_ref_timer
  import sdr_pkg::*;
#(
  parameter int REF_INTERVAL = 1300
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap,
  output logic o_pending,
  output logic o_overrun
);

  localparam logic [10:0] CNT_LAST = 11'(REF_INTERVAL - 1);

  logic [10:0] r_cnt;
  logic        r_pending;
  logic        r_overrun;

  assign o_wrap    = i_en && (r_cnt == CNT_LAST);
  assign o_pending = r_pending;
  assign o_overrun = r_overrun;

  // Interval counter plus pending/overrun flags; a wrap wins over a clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= 11'd0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (!i_en || o_wrap) r_cnt <= 11'd0;
      else                 r_cnt <= r_cnt + 11'd1;

      if (o_wrap) begin
        r_pending <= 1'b1;
        if (r_pending && !i_clr) r_overrun <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdr_arb.sv
// SDRAM command-bus arbiter. Grants the bus to the write or read engine
// (round-robin on ties), schedules PRECHARGE-ALL + AUTO REFRESH when the
// refresh timer wraps, and muxes the owning party's command onto the bus.
// Handshake: i_wr_req/i_rd_req are levels held until the matching one-cycle
// o_*_start pulse; the engine later returns a one-cycle i_*_exit pulse.
module sdr_arb
  import sdr_pkg::*;
#(
  parameter int REF_INTERVAL = 1300,
  parameter int NRP          = 3,
  parameter int NRFC         = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init_done,
  input  logic              i_wr_req,
  input  logic              i_rd_req,
  output logic              o_wr_start,
  output logic              o_rd_start,
  input  logic              i_wr_exit,
  input  logic              i_rd_exit,
  input  logic [CMD_W-1:0]  i_wr_cmd,
  input  logic [CMD_W-1:0]  i_rd_cmd,
  output logic              o_need_ref,
  output logic              o_ref_overrun,
  output logic [1:0]        o_owner,
  output logic [BA_W-1:0]   o_sdr_BA,
  output logic [A_W-1:0]    o_sdr_A,
  output logic              o_sdr_nRAS,
  output logic              o_sdr_nCAS,
  output logic              o_sdr_nWE,
  output state_t            o_state
);

  state_t           r_state;
  logic [3:0]       r_phase;
  logic [1:0]       r_last;
  logic [1:0]       r_owner;
  logic             r_wr_start;
  logic             r_rd_start;
  logic [CMD_W-1:0] r_ref_cmd;

  logic             w_wrap;
  logic             w_pending;
  logic             w_ref_due;
  logic             w_ref_clr;
  logic             w_grant_wr;
  logic             w_grant_rd;
  logic [CMD_W-1:0] w_bus;

  // A wrap in this cycle counts as pending so it beats a same-cycle request
  assign w_ref_due  = w_pending | w_wrap;
  // Pending clears on the edge that puts AUTO REFRESH on the bus
  assign w_ref_clr  = (r_state == S_REF_PRE) && (r_phase == 4'd0);
  assign w_grant_wr = i_wr_req && (!i_rd_req || (r_last == OWN_RD));
  assign w_grant_rd = i_rd_req && !w_grant_wr;

  sdr_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_ref_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (r_state != S_INIT),
    .i_clr     (w_ref_clr),
    .o_wrap    (w_wrap),
    .o_pending (w_pending),
    .o_overrun (o_ref_overrun)
  );

  // Arbitration FSM with registered owner, start pulses and refresh command
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_INIT;
      r_phase    <= 4'd0;
      r_last     <= OWN_RD;
      r_owner    <= OWN_NONE;
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      r_ref_cmd  <= BUNDLE_NOP;
    end else begin
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      r_ref_cmd  <= BUNDLE_NOP;
      case (r_state)
        S_INIT: begin
          if (i_init_done) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_ref_due) begin
            r_state   <= S_REF_PRE;
            r_owner   <= OWN_REF;
            r_phase   <= 4'(NRP - 1);
            r_ref_cmd <= BUNDLE_PRE;
          end else if (w_grant_wr) begin
            r_state    <= S_WR;
            r_owner    <= OWN_WR;
            r_last     <= OWN_WR;
            r_wr_start <= 1'b1;
          end else if (w_grant_rd) begin
            r_state    <= S_RD;
            r_owner    <= OWN_RD;
            r_last     <= OWN_RD;
            r_rd_start <= 1'b1;
          end
        end
        S_WR, S_RD: begin
          if ((r_state == S_WR) ? i_wr_exit : i_rd_exit) begin
            if (w_ref_due) begin
              r_state   <= S_REF_PRE;
              r_owner   <= OWN_REF;
              r_phase   <= 4'(NRP - 1);
              r_ref_cmd <= BUNDLE_PRE;
            end else begin
              r_state <= S_IDLE;
              r_owner <= OWN_NONE;
            end
          end
        end
        S_REF_PRE: begin
          if (r_phase == 4'd0) begin
            r_state   <= S_REF_AR;
            r_phase   <= 4'(NRFC - 1);
            r_ref_cmd <= BUNDLE_AR;
          end else begin
            r_phase <= r_phase - 4'd1;
          end
        end
        S_REF_AR: begin
          if (r_phase == 4'd0) begin
            r_state <= S_IDLE;
            r_owner <= OWN_NONE;
          end else begin
            r_phase <= r_phase - 4'd1;
          end
        end
        default: begin
          r_state <= S_INIT;
          r_owner <= OWN_NONE;
        end
      endcase
    end
  end

  // Command bus mux, combinational from the owner register
  always_comb begin
    w_bus = BUNDLE_NOP;
    case (r_owner)
      OWN_WR:  w_bus = i_wr_cmd;
      OWN_RD:  w_bus = i_rd_cmd;
      OWN_REF: w_bus = r_ref_cmd;
      default: w_bus = BUNDLE_NOP;
    endcase
  end

  assign o_sdr_BA   = w_bus[BA_LSB +: BA_W];
  assign o_sdr_A    = w_bus[A_LSB +: A_W];
  assign o_sdr_nRAS = w_bus[NRAS_BIT];
  assign o_sdr_nCAS = w_bus[NCAS_BIT];
  assign o_sdr_nWE  = w_bus[NWE_BIT];
  assign o_owner    = r_owner;
  assign o_wr_start = r_wr_start;
  assign o_rd_start = r_rd_start;
  assign o_need_ref = w_pending;
  assign o_state    = r_state;

endmodule

// File: tb/tb_sdr_arb.sv
// Bench for sdr_arb: behavioural model of the arbiter checked every cycle,
// plus hand-computed expectations for the key timing points.
module tb_sdr_arb;
  import sdr_pkg::*;

  localparam int REF_INTERVAL = 1300;
  localparam int NRP          = 3;
  localparam int NRFC         = 11;
  localparam int REF_LEN      = NRP + NRFC;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_done, wr_req, rd_req, wr_exit, rd_exit;
  logic [17:0] wr_cmd, rd_cmd;
  logic        o_wr_start, o_rd_start, o_need_ref, o_ref_overrun;
  logic [1:0]  o_owner;
  logic [1:0]  o_sdr_BA;
  logic [12:0] o_sdr_A;
  logic        o_sdr_nRAS, o_sdr_nCAS, o_sdr_nWE;
  state_t      dbg_state;

  always #3 clk = ~clk;

  sdr_arb #(
    .REF_INTERVAL (REF_INTERVAL),
    .NRP          (NRP),
    .NRFC         (NRFC)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_init_done   (init_done),
    .i_wr_req      (wr_req),
    .i_rd_req      (rd_req),
    .o_wr_start    (o_wr_start),
    .o_rd_start    (o_rd_start),
    .i_wr_exit     (wr_exit),
    .i_rd_exit     (rd_exit),
    .i_wr_cmd      (wr_cmd),
    .i_rd_cmd      (rd_cmd),
    .o_need_ref    (o_need_ref),
    .o_ref_overrun (o_ref_overrun),
    .o_owner       (o_owner),
    .o_sdr_BA      (o_sdr_BA),
    .o_sdr_A       (o_sdr_A),
    .o_sdr_nRAS    (o_sdr_nRAS),
    .o_sdr_nCAS    (o_sdr_nCAS),
    .o_sdr_nWE     (o_sdr_nWE),
    .o_state       (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 init, 1 idle, 2 write, 3 read, 4 refresh (pos = cycle in sequence)
  int m_mode, m_cnt, m_pos;
  bit m_pend, m_ovr, m_last_wr, m_wr_start, m_rd_start;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_pos = 0;
    m_pend = 0; m_ovr = 0; m_last_wr = 0;
    m_wr_start = 0; m_rd_start = 0;
  endtask

  task automatic model_step();
    bit wrap, due, clr;
    wrap = 0;
    if (m_mode != 0) begin
      if (m_cnt == REF_INTERVAL - 1) begin wrap = 1; m_cnt = 0; end
      else m_cnt++;
    end
    due = m_pend || wrap;
    clr = (m_mode == 4) && (m_pos == NRP - 1);
    if (wrap) begin
      if (m_pend && !clr) m_ovr = 1;
      m_pend = 1;
    end else if (clr) m_pend = 0;
    m_wr_start = 0;
    m_rd_start = 0;
    case (m_mode)
      0: if (init_done) m_mode = 1;
      1: begin
        if (due) begin m_mode = 4; m_pos = 0; end
        else if (wr_req && (!rd_req || !m_last_wr)) begin m_mode = 2; m_wr_start = 1; m_last_wr = 1; end
        else if (rd_req) begin m_mode = 3; m_rd_start = 1; m_last_wr = 0; end
      end
      2: if (wr_exit) begin if (due) begin m_mode = 4; m_pos = 0; end else m_mode = 1; end
      3: if (rd_exit) begin if (due) begin m_mode = 4; m_pos = 0; end else m_mode = 1; end
      4: if (m_pos == REF_LEN - 1) m_mode = 1; else m_pos++;
      default: m_mode = 0;
    endcase
  endtask

  function automatic logic [1:0] m_owner();
    case (m_mode)
      2: return 2'd1;
      3: return 2'd2;
      4: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic state_t m_state();
    case (m_mode)
      0: return S_INIT;
      1: return S_IDLE;
      2: return S_WR;
      3: return S_RD;
      default: return (m_pos < NRP) ? S_REF_PRE : S_REF_AR;
    endcase
  endfunction

  function automatic logic [17:0] m_bus();
    case (m_mode)
      2: return wr_cmd;
      3: return rd_cmd;
      4: begin
        if (m_pos == 0)   return {2'b00, 13'h0400, 3'b010};
        if (m_pos == NRP) return {2'b00, 13'h0000, 3'b001};
        return {2'b00, 13'h0000, 3'b111};
      end
      default: return {2'b00, 13'h0000, 3'b111};
    endcase
  endfunction

  task automatic check_all();
    check("owner",       o_owner,       m_owner());
    check("state",       dbg_state,     m_state());
    check("wr_start",    o_wr_start,    m_wr_start);
    check("rd_start",    o_rd_start,    m_rd_start);
    check("need_ref",    o_need_ref,    m_pend);
    check("ref_overrun", o_ref_overrun, m_ovr);
    check("bus", {o_sdr_BA, o_sdr_A, o_sdr_nRAS, o_sdr_nCAS, o_sdr_nWE}, m_bus());
  endtask

  // ---------------- drivers ----------------
  // eng_mode: 0 exit 20 after start, 1 random exit delay, 2 exit 5 after
  // need_ref rises, 3 exit only when kicked
  int wr_cnt = 0, rd_cnt = 0, eng_mode = 0;
  bit wr_kick = 0, rand_reqs = 0, prev_need = 0;

  task automatic engines();
    bit fire_w, fire_r;
    wr_cmd = 18'($urandom);
    rd_cmd = 18'($urandom);
    fire_w = 0;
    fire_r = 0;
    if (wr_cnt > 0) begin wr_cnt--; fire_w = (wr_cnt == 0); end
    if (rd_cnt > 0) begin rd_cnt--; fire_r = (rd_cnt == 0); end
    if (wr_kick) begin fire_w = 1; wr_kick = 0; end
    if (o_wr_start) begin
      if (eng_mode != 0) wr_req = 0;
      case (eng_mode)
        0: wr_cnt = 20;
        1: wr_cnt = $urandom_range(1, 30);
        default: wr_cnt = 0;
      endcase
    end
    if (o_rd_start) begin
      if (eng_mode != 0) rd_req = 0;
      case (eng_mode)
        0: rd_cnt = 20;
        1: rd_cnt = $urandom_range(1, 30);
        default: rd_cnt = 0;
      endcase
    end
    if (eng_mode == 2 && o_need_ref && !prev_need) wr_cnt = 5;
    prev_need = o_need_ref;
    if (rand_reqs) begin
      if (!wr_req && $urandom_range(0, 7) == 0) wr_req = 1;
      if (!rd_req && $urandom_range(0, 7) == 0) rd_req = 1;
    end
    // stray exits from the engine that does not own the bus
    if (eng_mode == 1 && m_mode == 2 && $urandom_range(0, 7) == 0) fire_r = 1;
    if (eng_mode == 1 && m_mode == 3 && $urandom_range(0, 7) == 0) fire_w = 1;
    wr_exit = fire_w;
    rd_exit = fire_r;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    check_all();
    engines();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_owner"},    o_owner,       2'd0);
    check({tag, "_wr_start"}, o_wr_start,    1'b0);
    check({tag, "_rd_start"}, o_rd_start,    1'b0);
    check({tag, "_need_ref"}, o_need_ref,    1'b0);
    check({tag, "_overrun"},  o_ref_overrun, 1'b0);
    check({tag, "_bus"}, {o_sdr_BA, o_sdr_A, o_sdr_nRAS, o_sdr_nCAS, o_sdr_nWE},
          {2'b00, 13'h0000, 3'b111});
    check({tag, "_state"},    dbg_state,     S_INIT);
  endtask

  // Called at a negedge (or time 0): reset takes effect asynchronously
  task automatic apply_reset(input string tag);
    init_done = 0; wr_req = 0; rd_req = 0; wr_exit = 0; rd_exit = 0;
    wr_cmd = 18'($urandom); rd_cmd = 18'($urandom);
    wr_cnt = 0; rd_cnt = 0; wr_kick = 0; rand_reqs = 0; prev_need = 0;
    rst = 1;
    #1;
    check_reset_vals(tag);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, k, ar_at, nop_before, nop_after, starts, last_start;
    logic need_at_ar;
    logic [2:0] cmd;
    logic [1:0] got, want;

    // Idle bus after reset, first refresh interval
    apply_reset("rst0");
    repeat (3) step();
    init_done = 1;
    step();
    n = 0;
    while (!o_need_ref && n < 2000) begin step(); n++; end
    check("first_need_ref_delay", n, 1300);

    // Refresh while idle: PRE, 2 NOP, AR, 10 NOP
    check("pre_cmd", {o_sdr_nRAS, o_sdr_nCAS, o_sdr_nWE}, 3'b010);
    check("pre_a10", o_sdr_A[10], 1'b1);
    k = 0; ar_at = -1; nop_before = 0; nop_after = 0; need_at_ar = 1'bx;
    while (o_owner == 2'd3 && k < 40) begin
      cmd = {o_sdr_nRAS, o_sdr_nCAS, o_sdr_nWE};
      if (cmd == 3'b001) begin ar_at = k; need_at_ar = o_need_ref; end
      else if (cmd == 3'b111) begin
        if (ar_at < 0) nop_before++; else nop_after++;
      end
      step();
      k++;
    end
    check("ref_len", k, 14);
    check("ar_pos", ar_at, 3);
    check("need_ref_at_ar", need_at_ar, 1'b0);
    check("nops_before_ar", nop_before, 2);
    check("nops_after_ar", nop_after, 10);

    // Tied requests: WR, RD, WR, 22 cycles apart
    eng_mode = 0;
    exp_q = {2'd1, 2'd2, 2'd1};
    wr_req = 1; rd_req = 1;
    starts = 0; last_start = -1; k = 0;
    while (starts < 3 && k < 200) begin
      step();
      k++;
      if (o_wr_start || o_rd_start) begin
        got  = o_wr_start ? 2'd1 : 2'd2;
        want = exp_q.pop_front();
        check("tied_order", got, want);
        if (last_start >= 0) check("tied_gap", cyc - last_start, 22);
        last_start = cyc;
        starts++;
      end
    end
    check("tied_starts", starts, 3);
    wr_req = 0; rd_req = 0;
    repeat (30) step();

    // Refresh during a write
    n = 0;
    while (!(m_mode == 1 && m_cnt == REF_INTERVAL - 11) && n < 1500) begin step(); n++; end
    check("wait_ref_window", n < 1500, 1'b1);
    eng_mode = 2;
    wr_req = 1;
    n = 0;
    while (!o_need_ref && n < 50) begin step(); n++; end
    check("ref_mid_write_rise", o_need_ref, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("ref_wr_owner", o_owner, 2'd1);
      check("ref_wr_no_start", {o_wr_start, o_rd_start}, 2'b00);
      step();
    end
    check("ref_after_exit_owner", o_owner, 2'd3);
    check("ref_after_exit_cmd", {o_sdr_nRAS, o_sdr_nCAS, o_sdr_nWE}, 3'b010);
    repeat (20) step();

    // Randomized traffic
    eng_mode = 1;
    rand_reqs = 1;
    repeat (3000) step();
    rand_reqs = 0;
    wr_req = 0; rd_req = 0;
    repeat (60) step();

    // Overrun: write held across two wraps
    apply_reset("rst1");
    eng_mode = 3;
    init_done = 1;
    wr_req = 1;
    n = 0;
    while (!o_wr_start && n < 10) begin step(); n++; end
    check("ovr_write_granted", o_wr_start, 1'b1);
    repeat (2700) step();
    check("ovr_set", o_ref_overrun, 1'b1);
    check("ovr_need_ref", o_need_ref, 1'b1);
    wr_kick = 1;

    // Reset in cycle 3 of AUTO REFRESH
    n = 0;
    while (!(m_mode == 4 && m_pos == NRP + 2) && n < 40) begin step(); n++; end
    check("ovr_sticky", o_ref_overrun, 1'b1);
    check("reach_ar_cycle3", dbg_state, S_REF_AR);
    apply_reset("rst_mid_ref");
    repeat (2) step();
    check("restart_in_init", dbg_state, S_INIT);
    init_done = 1;
    repeat (5) step();
    check("restart_idle", dbg_state, S_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdr_arb.md
# sdr_arb

Command-bus arbiter and refresh scheduler for the SDRAM controller. It sits between the user-side request logic and the write engine (`sdr_wr`) and read engine (`sdr_rd`), and owns the single SDRAM command bus. It grants the bus to one engine at a time, keeps the auto-refresh interval timer, and raises `need_ref` so a running engine winds down at a burst boundary. It then issues PRECHARGE-ALL and AUTO REFRESH itself.

## Interface
- `REF_INTERVAL`, default 1300: cycles between refresh requests (7.8 µs at 167 MHz).
- `NRP`, default 3: cycles spent in precharge, including the command cycle.
- `NRFC`, default 11: cycles spent in auto-refresh, including the command cycle.
- `clk`  in  1  controller clock, 167 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `init_done`  in  1  level from the power-up init block. The arbiter stays idle until it is high.
- `wr_req`, `rd_req`  in  1 each  user requests. Level signals, held until the matching start pulse.
- `wr_start`, `rd_start`  out  1 each  single-cycle start pulses. They drive `sdr_wr_req` / `sdr_rd_req`.
- `wr_exit`, `rd_exit`  in  1 each  single-cycle completion pulses from the engines.
- `wr_cmd`, `rd_cmd`  in  18 each  engine command bundles, packed as {BA[1:0], A[12:0], nRAS, nCAS, nWE}.
- `need_ref`  out  1  refresh pending. Fanned out to both engines.
- `ref_overrun`  out  1  sticky: an interval elapsed while a refresh was already pending.
- `owner`  out  2  current bus owner: 0 none, 1 WR, 2 RD, 3 REF.
- `sdr_BA` (out, 2), `sdr_A` (out, 13), `sdr_nRAS` (out, 1), `sdr_nCAS` (out, 1), `sdr_nWE` (out, 1): muxed command bus.

## Operation
- States: S_INIT, S_IDLE, S_WR, S_RD, S_REF_PRE, S_REF_AR.
- S_INIT → S_IDLE when `init_done` is 1. The refresh timer is held at 0 while in S_INIT.
- Refresh timer counts 0..REF_INTERVAL-1 and wraps.
  - On wrap it sets `ref_pending`. `need_ref` equals `ref_pending`.
  - A wrap while `ref_pending` is already 1 sets `ref_overrun`. It is cleared only by `rst`.
- `ref_pending` clears in the cycle the AUTO REFRESH command is driven.
- Priority from S_IDLE: refresh first, then WR/RD round-robin.
  - `last` records the most recent grant (reset value: RD, so WR wins the first tie).
  - A sole requester always wins.
  - No grant is made while `need_ref` is 1.
- S_WR:
  - On `wr_exit`, go to S_REF_PRE if `need_ref`, otherwise S_IDLE.
  - `rd_exit` is ignored in S_WR.
- S_RD: symmetric to S_WR, using `rd_exit`.
- S_REF_PRE: lasts NRP cycles, then S_REF_AR.
  - First cycle: PRECHARGE (nRAS,nCAS,nWE = 010), A[10]=1, BA=0.
  - Remaining cycles: NOP.
- S_REF_AR: lasts NRFC cycles, then S_IDLE.
  - First cycle: AUTO REFRESH (001).
  - Remaining cycles: NOP.
- Bus mux:
  - owner WR → `wr_cmd`.
  - owner RD → `rd_cmd`.
  - owner REF → internal refresh command register.
  - owner none → NOP (111), BA=0, A=0.
- A preempted transfer is not resumed by the arbiter. The requester re-raises its request with the remaining count.
- Reset at any time: return to S_INIT and clear the timer, `ref_pending`, `last` and the phase counter. Outputs take their reset values immediately.

## Timing
- Reset values:
  - `sdr_nRAS` = `sdr_nCAS` = `sdr_nWE` = 1; `sdr_BA` = 0; `sdr_A` = 0.
  - `owner` = 0; `wr_start` = `rd_start` = 0; `need_ref` = 0; `ref_overrun` = 0.
- Grant latency: the request is sampled in S_IDLE at cycle t. At t+1 the state, `owner` and start pulse are all active. `wr_start`/`rd_start` is high only at t+1.
- Request and refresh wrap in the same cycle: refresh wins and no start pulse is issued.
- The `owner` register updates on state transitions. The bus mux is combinational from `owner`, so it adds no latency to engine commands.
- Exit-to-next-grant takes a minimum of 2 cycles: the exit edge leads to S_IDLE, then the grant is made.
- Refresh command register:
  - Loaded on the transition into S_REF_PRE / S_REF_AR, so the command is visible in the state's first cycle.
  - Set to NOP for every following cycle.
- Phase counter: 4 bits, loaded with NRP-1 or NRFC-1 on entry and decremented to 0. The state exits when the counter is 0.
- Refresh timer: 11 bits. REF_INTERVAL must be ≤ 2047.

## Structure
- `sdr_pkg`: command encodings (NOP, ACTIVE, READ, WRITE, PRECHARGE, AUTO_REFRESH), the state enum, owner codes, and the cmd bundle field offsets.
- Sub-module `sdr_ref_timer`: interval counter with enable, pending/overrun flags and a clear input.
- The FSM, phase counter and bus mux live in `sdr_arb`.

## Test plan
- Idle bus after reset:
  - Stimulus: assert `rst`, then release with `init_done`=1 and no requests.
  - Required: bus NOP, `owner`=0, first `need_ref` exactly 1300 cycles after `init_done`.
- Tied requests:
  - Stimulus: `wr_req` and `rd_req` both held; each engine pulses its exit 20 cycles after its start.
  - Required: start pulses alternate WR, RD, WR. Each is one cycle wide, and consecutive starts are 22 cycles apart.
- Refresh while idle:
  - Stimulus: timer wraps with no requests.
  - Required: PRECHARGE with A[10]=1, then 2 NOP cycles, then AUTO REFRESH, then 10 NOP cycles, then S_IDLE. `need_ref` drops in the AUTO REFRESH cycle.
- Refresh during a write:
  - Stimulus: `need_ref` rises mid-write; `wr_exit` follows 5 cycles later.
  - Required: no new grant in between; S_REF_PRE entered on the cycle after `wr_exit`; `owner` goes 1 then 3.
- Overrun:
  - Stimulus: `init_done` set; a write is granted and `wr_exit` is withheld for 2700 cycles.
  - Required: `ref_overrun`=1 after the second wrap and stays 1 until `rst`.
- Reset mid-refresh:
  - Stimulus: assert `rst` in cycle 3 of S_REF_AR.
  - Required: outputs immediately return to their reset values; the block restarts in S_INIT.
